// File: rtl/sem_pkg.sv
// sem_pkg: shared constants and types for the SEM command sequencer.
//   - sem_cmds state encodings seen on SEM_STATE
//   - command codes accepted on CMD_CODE
//   - ASCII characters and string lengths of the generated commands
//   - sequencer FSM state type and a code-to-letter helper
package sem_pkg;

  // Downstream sem_cmds handshake states.
  localparam logic [1:0] SEM_IDLE  = 2'b00;
  localparam logic [1:0] SEM_EMPTY = 2'b01;
  localparam logic [1:0] SEM_READY = 2'b10;

  // Command codes; anything above CMD_N is invalid.
  localparam logic [2:0] CMD_I = 3'd0;
  localparam logic [2:0] CMD_O = 3'd1;
  localparam logic [2:0] CMD_S = 3'd2;
  localparam logic [2:0] CMD_R = 3'd3;
  localparam logic [2:0] CMD_N = 3'd4;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_I     = 8'h49;
  localparam logic [7:0] ASCII_O     = 8'h4F;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_N     = 8'h4E;

  // Byte counts: letter + CR, or 'N' + space + 10 hex digits + CR.
  localparam logic [3:0] LEN_SHORT = 4'd2;
  localparam logic [3:0] LEN_INJ   = 4'd13;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_REQ  = 3'd2,
    ST_REL  = 3'd3,
    ST_FIN  = 3'd4
  } seq_state_t;

  // First byte of every command string.
  function automatic logic [7:0] cmd_letter(input logic [2:0] code);
    case (code)
      CMD_I:   return ASCII_I;
      CMD_O:   return ASCII_O;
      CMD_S:   return ASCII_S;
      CMD_R:   return ASCII_R;
      CMD_N:   return ASCII_N;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/sem_hex2ascii.sv
// sem_hex2ascii: combinational nibble to uppercase ASCII hex digit.
//   i_nib  [3:0] : nibble value 0..15
//   o_char [7:0] : '0'..'9' (0x30..0x39) or 'A'..'F' (0x41..0x46)
module sem_hex2ascii
  import sem_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [7:0] o_char
);

  // Offset so that nibble 10 lands on 'A'.
  localparam logic [7:0] ALPHA_BASE = ASCII_A - 8'd10;

  always_comb begin
    if (i_nib < 4'd10) o_char = ASCII_ZERO + {4'h0, i_nib};
    else               o_char = ALPHA_BASE + {4'h0, i_nib};
  end

endmodule

// File: rtl/sem_cmd_seq.sv
// sem_cmd_seq: expands a one-shot command request into an ASCII byte
// string and hands it to sem_cmds one byte per SEND handshake.
//   CLK, RST          : clock, synchronous active-high reset
//   CMD_CODE [2:0]    : command select (0..4 valid), sampled on CMD_STRB
//   CMD_STRB          : one-cycle request strobe (honoured only when idle)
//   INJ_ADDR [39:0]   : inject address for code 4, sampled on CMD_STRB
//   SEM_STATE [1:0]   : sem_cmds state (Idle/Empty/Ready)
//   SEND              : byte request to sem_cmds
//   CMD_BYTE [7:0]    : current byte, 0x00 when idle
//   BUSY              : command in progress
//   DONE              : one-cycle pulse after the last byte was taken
//   ERR               : one-cycle pulse on invalid code or wait timeout
module sem_cmd_seq
  import sem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  CMD_CODE,
  input  logic        CMD_STRB,
  input  logic [39:0] INJ_ADDR,
  input  logic [1:0]  SEM_STATE,
  output logic        SEND,
  output logic [7:0]  CMD_BYTE,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  localparam int            CW       = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  seq_state_t    r_state;
  logic [2:0]    r_code;
  logic [39:0]   r_addr;
  logic [3:0]    r_idx;
  logic [CW-1:0] r_cnt;

  logic [3:0] w_nidx;
  logic [3:0] w_nib;
  logic [7:0] w_hex;
  logic [7:0] w_next_byte;
  logic       w_last;
  logic       w_timeout;

  assign w_nidx    = r_idx + 4'd1;
  assign w_last    = (r_idx == (((r_code == CMD_N) ? LEN_INJ : LEN_SHORT) - 4'd1));
  // The current wait has lasted TIMEOUT_CYC cycles once this cycle ends.
  assign w_timeout = (r_cnt == CNT_LAST);

  // Address digit for the upcoming byte; index 2 carries the MS nibble.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_nib = 4'h0;
    case (w_nidx)
      4'd2:    w_nib = r_addr[39:36];
      4'd3:    w_nib = r_addr[35:32];
      4'd4:    w_nib = r_addr[31:28];
      4'd5:    w_nib = r_addr[27:24];
      4'd6:    w_nib = r_addr[23:20];
      4'd7:    w_nib = r_addr[19:16];
      4'd8:    w_nib = r_addr[15:12];
      4'd9:    w_nib = r_addr[11:8];
      4'd10:   w_nib = r_addr[7:4];
      4'd11:   w_nib = r_addr[3:0];
      default: w_nib = 4'h0;
    endcase
  end

  sem_hex2ascii u_hex (
    .i_nib  (w_nib),
    .o_char (w_hex)
  );

  // Byte 0 is loaded straight from CMD_CODE on the strobe; this mux covers
  // bytes 1..12 from the latched code and address.
  always_comb begin
    w_next_byte = ASCII_CR;
    if (w_nidx == 4'd1)
      w_next_byte = (r_code == CMD_N) ? ASCII_SPACE : ASCII_CR;
    else if ((w_nidx >= 4'd2) && (w_nidx <= 4'd11))
      w_next_byte = w_hex;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_code   <= 3'd0;
      r_addr   <= 40'd0;
      r_idx    <= 4'd0;
      r_cnt    <= '0;
      SEND     <= 1'b0;
      CMD_BYTE <= 8'h00;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (CMD_STRB) begin
            if (CMD_CODE <= CMD_N) begin
              r_code   <= CMD_CODE;
              r_addr   <= INJ_ADDR;
              r_idx    <= 4'd0;
              r_cnt    <= '0;
              CMD_BYTE <= cmd_letter(CMD_CODE);
              BUSY     <= 1'b1;
              r_state  <= ST_LOAD;
            end else begin
              ERR <= 1'b1;
            end
          end
        end

        ST_LOAD, ST_REQ, ST_REL: begin
          if ((r_state == ST_LOAD) && (SEM_STATE == SEM_IDLE)) begin
            SEND    <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_REQ;
          end else if ((r_state == ST_REQ) && (SEM_STATE == SEM_EMPTY)) begin
            SEND    <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_REL;
          end else if ((r_state == ST_REL) && (SEM_STATE == SEM_IDLE)) begin
            r_cnt <= '0;
            if (w_last) begin
              // DONE and BUSY change together while FIN is occupied.
              DONE     <= 1'b1;
              BUSY     <= 1'b0;
              CMD_BYTE <= 8'h00;
              r_state  <= ST_FIN;
            end else begin
              r_idx    <= w_nidx;
              CMD_BYTE <= w_next_byte;
              r_state  <= ST_LOAD;
            end
          end else if (w_timeout) begin
            SEND     <= 1'b0;
            BUSY     <= 1'b0;
            CMD_BYTE <= 8'h00;
            ERR      <= 1'b1;
            r_cnt    <= '0;
            r_state  <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        ST_FIN: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sem_cmd_seq.sv
// tb_sem_cmd_seq: self-checking bench for sem_cmd_seq.
// A downstream responder emulates sem_cmds; a behavioural model predicts
// every output each cycle from the command string and handshake progress.
module tb_sem_cmd_seq;

  localparam int         TO      = 16;
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_EMPTY = 2'b01;
  localparam logic [1:0] S_READY = 2'b10;

  logic        CLK;
  logic        RST;
  logic [2:0]  CMD_CODE;
  logic        CMD_STRB;
  logic [39:0] INJ_ADDR;
  logic [1:0]  SEM_STATE;
  logic        SEND;
  logic [7:0]  CMD_BYTE;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  sem_cmd_seq #(.TIMEOUT_CYC(TO)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CMD_CODE  (CMD_CODE),
    .CMD_STRB  (CMD_STRB),
    .INJ_ADDR  (INJ_ADDR),
    .SEM_STATE (SEM_STATE),
    .SEND      (SEND),
    .CMD_BYTE  (CMD_BYTE),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [103:0] got, input logic [103:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- command strings from the byte rules ----------------
  function automatic logic [7:0] hex_char(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
  endfunction

  // Byte i sits at [103-8i -: 8]; unused tail bytes are zero.
  function automatic logic [103:0] build_str(input logic [2:0] code, input logic [39:0] addr);
    logic [103:0] s;
    logic [7:0]   letter;
    s = '0;
    case (code)
      3'd0:    letter = 8'h49;
      3'd1:    letter = 8'h4F;
      3'd2:    letter = 8'h53;
      3'd3:    letter = 8'h52;
      default: letter = 8'h4E;
    endcase
    s[103:96] = letter;
    if (code == 3'd4) begin
      s[95:88] = 8'h20;
      for (int i = 0; i < 10; i++)
        s[87-8*i -: 8] = hex_char(int'((addr >> (36 - 4*i)) & 40'hF));
      s[7:0] = 8'h0D;
    end else begin
      s[95:88] = 8'h0D;
    end
    return s;
  endfunction

  function automatic int str_len(input logic [2:0] code);
    return (code == 3'd4) ? 13 : 2;
  endfunction

  function automatic logic [7:0] str_byte(input logic [103:0] s, input int k);
    return s[103-8*k -: 8];
  endfunction

  // ---------------- downstream sem_cmds responder ----------------
  logic [1:0] ds_state;
  bit never_ack = 0;
  int ack_min = 0, ack_max = 3, rel_max = 2;
  int ack_cd, rel_cd;

  initial begin
    ds_state  = S_IDLE;
    SEM_STATE = S_IDLE;
    forever begin
      @(posedge CLK);
      #1;
      if (RST) ds_state = S_IDLE;
      else begin
        case (ds_state)
          S_IDLE: if (SEND) begin
            ds_state = S_READY;
            ack_cd   = $urandom_range(ack_max, ack_min);
          end
          S_READY: begin
            if (!SEND) ds_state = S_IDLE;
            else if (!never_ack) begin
              if (ack_cd == 0) begin
                ds_state = S_EMPTY;
                rel_cd   = $urandom_range(rel_max, 0);
              end else ack_cd--;
            end
          end
          default: if (!SEND) begin
            if (rel_cd == 0) ds_state = S_IDLE;
            else rel_cd--;
          end
        endcase
      end
      SEM_STATE = ds_state;
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  bit           m_valid = 0, m_active = 0, m_fin = 0, m_send = 0, m_acked = 0;
  bit           e_done = 0, e_err = 0;
  int           m_k = 0, m_len = 0, m_wait = 0;
  logic [103:0] m_str = '0;

  logic [7:0] q_sent[$];
  int  send_cycles = 0, n_done = 0, n_errpulse = 0;
  bit  prev_send = 0;

  // Advance the model by one clock using the inputs the DUT is about to sample.
  task automatic model_step();
    bit progress;
    e_done = 0;
    e_err  = 0;
    if (RST) begin
      m_active = 0; m_fin = 0; m_send = 0; m_acked = 0;
      m_k = 0; m_wait = 0; m_valid = 1;
      return;
    end
    if (m_fin) begin
      m_fin = 0;
    end else if (!m_active) begin
      if (CMD_STRB) begin
        if (CMD_CODE <= 3'd4) begin
          m_active = 1; m_send = 0; m_acked = 0; m_k = 0; m_wait = 0;
          m_str = build_str(CMD_CODE, INJ_ADDR);
          m_len = str_len(CMD_CODE);
        end else e_err = 1;
      end
    end else begin
      progress = 0;
      if (m_acked) begin
        if (SEM_STATE == S_IDLE) begin
          progress = 1;
          if (m_k == m_len - 1) begin
            m_active = 0; m_acked = 0; m_fin = 1; e_done = 1;
          end else begin
            m_k++; m_acked = 0;
          end
        end
      end else if (m_send) begin
        if (SEM_STATE == S_EMPTY) begin
          progress = 1; m_send = 0; m_acked = 1;
        end
      end else if (SEM_STATE == S_IDLE) begin
        progress = 1; m_send = 1;
      end
      if (progress) m_wait = 0;
      else if (m_wait == TO - 1) begin
        m_active = 0; m_send = 0; m_acked = 0; e_err = 1; m_wait = 0;
      end else m_wait++;
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (m_valid) begin
        check("SEND", 104'(SEND), 104'(m_send));
        check("BUSY", 104'(BUSY), 104'(m_active));
        check("DONE", 104'(DONE), 104'(e_done));
        check("ERR",  104'(ERR),  104'(e_err));
        if (!e_done)
          check("CMD_BYTE", 104'(CMD_BYTE), 104'(m_active ? str_byte(m_str, m_k) : 8'h00));
      end
      if (SEND && !prev_send) q_sent.push_back(CMD_BYTE);
      if (SEND) send_cycles++;
      if (DONE) n_done++;
      if (ERR)  n_errpulse++;
      prev_send = SEND;
      model_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [103:0] pack_q();
    logic [103:0] r;
    r = '0;
    for (int i = 0; i < q_sent.size() && i < 13; i++) r[103-8*i -: 8] = q_sent[i];
    return r;
  endfunction

  task automatic strobe(input logic [2:0] code, input logic [39:0] addr);
    @(posedge CLK); #2;
    CMD_STRB = 1'b1; CMD_CODE = code; INJ_ADDR = addr;
    @(posedge CLK); #2;
    CMD_STRB = 1'b0;
  endtask

  // mode 0: quiet; 1: random strobes while busy; 2: one code-0 strobe at cycle 10.
  task automatic wait_end(input int budget, input int mode);
    int base;
    bit fin;
    base = n_done + n_errpulse;
    fin  = 0;
    for (int c = 0; c < budget && !fin; c++) begin
      @(posedge CLK); #2;
      CMD_STRB = 1'b0;
      if (n_done + n_errpulse != base) fin = 1;
      else if (BUSY && !RST) begin
        if ((mode == 1 && $urandom_range(7, 0) == 0) || (mode == 2 && c == 10)) begin
          CMD_STRB = 1'b1;
          CMD_CODE = (mode == 2) ? 3'd0 : 3'($urandom_range(7, 0));
          INJ_ADDR = {8'($urandom), 32'($urandom)};
        end
      end
    end
    if (!fin) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_end: no DONE or ERR within %0d cycles", budget);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- test sequence ----------------
  initial begin
    int d0, e0, sc0, found;
    logic [103:0] s;
    logic [2:0]   code;
    logic [39:0]  addr;

    RST = 1'b1; CMD_STRB = 1'b0; CMD_CODE = 3'd0; INJ_ADDR = 40'd0;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
    check("rst_send", 104'(SEND), 104'(0));
    check("rst_busy", 104'(BUSY), 104'(0));
    check("rst_byte", 104'(CMD_BYTE), 104'(0));

    // Pin the string builder against hand-derived byte streams.
    s = build_str(3'd4, 40'h00C0FFEE12);
    check("pin_inj_c0ffee", s, 104'h4E20303043304646454531320D);
    s = build_str(3'd4, 40'h9A0F5B3C7D);
    check("pin_inj_digits", s, 104'h4E20394130463542334337440D);
    s = build_str(3'd3, 40'hFFFFFFFFFF);
    check("pin_r", s, {8'h52, 8'h0D, 88'h0});

    // Code 2 with a 3-cycle ACK.
    ack_min = 3; ack_max = 3; rel_max = 0;
    q_sent.delete(); d0 = n_done;
    strobe(3'd2, 40'd0);
    wait_end(200, 0);
    check("s_count", 104'(q_sent.size()), 104'(2));
    check("s_bytes", pack_q(), {8'h53, 8'h0D, 88'h0});
    check("s_done",  104'(n_done - d0), 104'(1));

    // Inject with a stray code-0 strobe mid-sequence.
    ack_min = 0; ack_max = 4; rel_max = 2;
    q_sent.delete(); d0 = n_done; e0 = n_errpulse;
    strobe(3'd4, 40'h00C0FFEE12);
    wait_end(400, 2);
    check("inj_count", 104'(q_sent.size()), 104'(13));
    check("inj_bytes", pack_q(), 104'h4E20303043304646454531320D);
    check("inj_done",  104'(n_done - d0), 104'(1));
    check("inj_noerr", 104'(n_errpulse - e0), 104'(0));

    // Invalid code then a valid one.
    e0 = n_errpulse; sc0 = send_cycles;
    strobe(3'd6, 40'd0);
    check("inv_err_t1", 104'(ERR),  104'(1));
    check("inv_busy",   104'(BUSY), 104'(0));
    repeat (3) @(posedge CLK);
    #2;
    check("inv_err_cnt", 104'(n_errpulse - e0), 104'(1));
    check("inv_nosend",  104'(send_cycles - sc0), 104'(0));
    q_sent.delete();
    strobe(3'd3, 40'd0);
    wait_end(200, 0);
    check("after_inv_bytes", pack_q(), {8'h52, 8'h0D, 88'h0});

    // Watchdog: downstream never acknowledges.
    never_ack = 1;
    sc0 = send_cycles; d0 = n_done; e0 = n_errpulse;
    strobe(3'd0, 40'd0);
    wait_end(200, 0);
    check("to_send_cycles", 104'(send_cycles - sc0), 104'(16));
    check("to_err",  104'(n_errpulse - e0), 104'(1));
    check("to_done", 104'(n_done - d0), 104'(0));
    never_ack = 0;
    repeat (3) @(posedge CLK);

    // Reset during REQ of the fifth inject byte.
    q_sent.delete(); d0 = n_done; e0 = n_errpulse; found = 0;
    strobe(3'd4, 40'h123456789A);
    for (int c = 0; c < 300 && !found; c++) begin
      @(posedge CLK); #2;
      if (q_sent.size() == 5 && SEND) found = 1;
    end
    check("rst_reached_byte5", 104'(found), 104'(1));
    RST = 1'b1;
    @(posedge CLK); #1;
    check("rst_mid_send", 104'(SEND), 104'(0));
    check("rst_mid_busy", 104'(BUSY), 104'(0));
    check("rst_mid_byte", 104'(CMD_BYTE), 104'(0));
    #1 RST = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    check("rst_mid_nodone", 104'(n_done - d0), 104'(0));
    check("rst_mid_noerr",  104'(n_errpulse - e0), 104'(0));
    q_sent.delete();
    strobe(3'd1, 40'd0);
    wait_end(200, 0);
    check("post_rst_bytes", pack_q(), {8'h4F, 8'h0D, 88'h0});

    // Randomised commands, handshake delays and ignored strobes.
    for (int it = 0; it < 40; it++) begin
      ack_min = 0; ack_max = $urandom_range(5, 0); rel_max = $urandom_range(3, 0);
      code = 3'($urandom_range(7, 0));
      addr = {8'($urandom), 32'($urandom)};
      q_sent.delete(); d0 = n_done; e0 = n_errpulse;
      strobe(code, addr);
      wait_end(400, 1);
      if (code <= 3'd4) begin
        check("rnd_count", 104'(q_sent.size()), 104'(str_len(code)));
        check("rnd_bytes", pack_q(), build_str(code, addr));
        check("rnd_done",  104'(n_done - d0), 104'(1));
        check("rnd_noerr", 104'(n_errpulse - e0), 104'(0));
      end else begin
        check("rnd_inv_err",  104'(n_errpulse - e0), 104'(1));
        check("rnd_inv_done", 104'(n_done - d0), 104'(0));
      end
    end

    repeat (3) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sem_cmd_seq.md
# sem_cmd_seq

Command sequencer placed directly upstream of the SEM command handshake FSM (`sem_cmds`). It accepts a one-shot command request from the slow-control register bank and expands it into an ASCII byte string for the Xilinx SEM controller monitor interface. It presents the string one byte at a time, driving `SEND` and pacing itself on the downstream `SEM_STATE`. Its outputs feed `sem_cmds.SEND` and the SEM core's monitor receive data.

## Interface
- `TIMEOUT_CYC`, default 4096: watchdog limit in CLK cycles for any single wait state. Must be ≥ 2.
- `CLK` input 1: single clock for the block.
- `RST` input 1: reset, synchronous, active-high.
- `CMD_CODE` input 3: command select, sampled on `CMD_STRB`.
  - 0 = 'I'
  - 1 = 'O'
  - 2 = 'S'
  - 3 = 'R'
  - 4 = 'N' inject
  - 5–7 invalid
- `CMD_STRB` input 1: one-cycle request strobe.
- `INJ_ADDR` input 40: inject address, sampled on `CMD_STRB`, used only for code 4.
- `SEM_STATE` input 2: state of `sem_cmds`. Encodings: Idle = 00, Empty = 01, Ready = 10.
- `SEND` output 1: request to `sem_cmds`.
- `CMD_BYTE` output 8: current ASCII byte to the SEM monitor rxdata.
- `BUSY` output 1: high from the cycle after an accepted strobe until completion.
- `DONE` output 1: one-cycle pulse when the last byte has been handed over.
- `ERR` output 1: one-cycle pulse on an invalid code or a timeout.

## Operation
- Byte strings:
  - Codes 0–3: letter, then CR (0x0D); 2 bytes.
  - Code 4: 'N', space (0x20), 10 hex digits of `INJ_ADDR` (MS nibble first), CR; 13 bytes.
  - Hex digits are uppercase. Nibble 0–9 maps to 0x30+n; nibble 10–15 maps to 0x41+(n−10).
- FSM states: IDLE, LOAD, REQ, REL, FIN.
  - IDLE: `CMD_STRB` with a valid code latches `CMD_CODE` and `INJ_ADDR`, clears the byte index, and moves to LOAD. `CMD_STRB` with an invalid code pulses `ERR` next cycle and stays in IDLE.
  - LOAD: `CMD_BYTE` holds byte[index]. When `SEM_STATE`==Idle, go to REQ.
  - REQ: `SEND`=1. When `SEM_STATE`==Empty (ACK consumed by downstream), go to REL.
  - REL: `SEND`=0. When `SEM_STATE`==Idle: if this was the last byte, go to FIN; otherwise increment index and go to LOAD.
  - FIN: pulse `DONE`, go to IDLE.
- `CMD_STRB` outside IDLE is ignored: no queueing, no `ERR`.
- Watchdog:
  - A cycle counter clears on every state entry.
  - In LOAD, REQ or REL, reaching `TIMEOUT_CYC` forces `SEND`=0, pulses `ERR`, and returns to IDLE. No `DONE` is issued.
- `CMD_BYTE` is stable for the whole of LOAD, REQ and REL of a byte. It changes only on the LOAD entry of the next byte. It is 0x00 in IDLE.
- Reset values: `SEND`=0, `BUSY`=0, `DONE`=0, `ERR`=0, `CMD_BYTE`=0x00, state IDLE, counters 0.
- `RST` mid-command aborts immediately. `SEND` is low on the cycle after the `RST` edge; no `DONE` and no `ERR` are issued.

## Timing
- Strobe sampled at edge t:
  - `BUSY`=1 and `CMD_BYTE` valid at t+1.
  - If `SEM_STATE`=Idle, `SEND`=1 at t+2.
- `SEND` falls one cycle after `SEM_STATE` reads Empty.
- Next byte's LOAD begins one cycle after `SEM_STATE` reads Idle in REL.
- With a zero-delay ACK from the SEM core, each byte costs 4 cycles minimum (LOAD, REQ + Ready, REL, Idle).
- `DONE` is asserted in the cycle after the final REL exit. `BUSY` drops in the same cycle as `DONE`.
- `ERR` for an invalid code is asserted at t+1; `BUSY` never rises in that case.
- All outputs are registered.

## Structure
- Shared package `sem_pkg` holds:
  - `SEM_STATE` encodings (Idle/Empty/Ready).
  - Command code constants (CMD_I, CMD_O, CMD_S, CMD_R, CMD_N).
  - ASCII constants (CR, SPACE, letters).
  - Byte-count constants (2, 13).
- One sub-module is natural: `sem_hex2ascii`, a combinational 4-bit to 8-bit ASCII converter used for the address digits.
- Byte select is a mux over the index (0..12) and the latched code/address.

## Test plan
- Code 2 ('S'), downstream model ACKs 3 cycles after Ready → bytes 0x53, 0x0D each seen once with `SEND` high; `DONE` pulses once; `BUSY` is high throughout.
- Code 4 with `INJ_ADDR`=0x00C0FFEE12 → byte stream 4E 20 30 30 43 30 46 46 45 45 31 32 0D in order; `DONE` after the 13th byte.
- Code 6 → `ERR` at t+1; `SEND` and `BUSY` never assert; the next valid strobe is accepted normally.
- `TIMEOUT_CYC`=16, downstream never ACKs → `SEND` high for 16 cycles, then drops; `ERR` pulses; no `DONE`; `BUSY` returns to 0.
- Second `CMD_STRB` (code 0) during a code 4 sequence → ignored; only the code 4 bytes appear; one `DONE`.
- `RST` asserted while in REQ of byte 5 of an inject → `SEND`, `BUSY` and `CMD_BYTE` are 0 the next cycle; no `DONE` or `ERR`; a fresh code 1 then produces 0x4F, 0x0D.
